// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch path:
//   MIPS_NOP      - instruction word presented to decode out of reset
//   PC_INCR       - byte distance between sequential instructions
//   fetch_state_e - fetch FSM state encoding
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
    localparam int          PC_INCR  = 4;

    typedef enum logic [1:0] {
        REQ  = 2'd0,  // latch the PC, start a new read
        WAIT = 2'd1,  // read outstanding, waiting for imem_ack
        OUT  = 2'd2,  // instruction offered to decode
        ERR  = 2'd3   // memory timeout, terminal until reset
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the two handshakes of the fetch unit:
//   imem_req/imem_addr -> imem_ack/imem_rdata   instruction-memory read
//   id_valid/id_instr/id_pc/id_pc_plus4 <-> id_ready   delivery to decode
// Modports:
//   master - the fetch unit (issues reads, offers instructions)
//   slave  - the environment (memory and decode)
// -----------------------------------------------------------------------------
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    logic              id_valid;
    logic              id_ready;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc_plus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output id_valid, id_instr, id_pc, id_pc_plus4,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  id_valid, id_instr, id_pc, id_pc_plus4,
        output id_ready
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// -----------------------------------------------------------------------------
// fetch_timeout_ctr
// Saturating up-counter measuring how long a memory read has been waiting.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear (priority over en)
//   en         - count one cycle
//   tc         - terminal count: counter holds TIMEOUT-1
// -----------------------------------------------------------------------------
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !tc) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign tc = (count_q == LAST);

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage between the program counter and IF/ID. Reads the
// word at pc_addr from instruction memory and offers it to decode; pc_en
// pulses only when decode accepts it, so the PC never runs ahead.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   pc_addr    - current PC value
//   pc_en      - PC may load its next value at the coming edge
//   flush      - branch/jump redirect (PC reloaded externally at same edge)
//   fetch_err  - sticky memory-timeout error
//   bus        - imem read and decode handshakes (master side)
// -----------------------------------------------------------------------------
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_en,
    input  logic              flush,
    output logic              fetch_err,
    if_fetch_unit_if.master   bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] id_instr_q;
    logic [ADDR_W-1:0] id_pc_q;
    logic [ADDR_W-1:0] id_pc_plus4_q;

    logic addr_load;
    logic load_out;
    logic ctr_clr;
    logic ctr_en;
    logic ctr_tc;

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .tc    (ctr_tc)
    );

    // Next-state and strobe logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d   = state_q;
        drop_d    = drop_q;
        addr_load = 1'b0;
        load_out  = 1'b0;
        ctr_clr   = 1'b0;
        ctr_en    = 1'b0;
        pc_en     = 1'b0;

        unique case (state_q)
            REQ: begin
                ctr_clr = 1'b1;
                // On flush the PC is being reloaded at this edge; sample it
                // on the following cycle instead.
                if (!flush) begin
                    addr_load = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                ctr_en = 1'b1;
                if (bus.imem_ack) begin
                    drop_d = 1'b0;
                    if (drop_q || flush) begin
                        state_d = REQ;
                    end else begin
                        load_out = 1'b1;
                        state_d  = OUT;
                    end
                end else if (ctr_tc) begin
                    state_d = ERR;
                end else if (flush) begin
                    // Keep the request up until memory answers; the stale
                    // word is thrown away when it arrives.
                    drop_d = 1'b1;
                end
            end
            OUT: begin
                if (flush) begin
                    state_d = REQ;
                end else if (bus.id_ready) begin
                    pc_en   = 1'b1;
                    state_d = REQ;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= REQ;
            addr_q        <= '0;
            drop_q        <= 1'b0;
            id_instr_q    <= DATA_W'(MIPS_NOP);
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (addr_load) begin
                addr_q <= pc_addr;
            end
            if (load_out) begin
                id_instr_q    <= bus.imem_rdata;
                id_pc_q       <= addr_q;
                id_pc_plus4_q <= addr_q + ADDR_W'(PC_INCR);  // wraps mod 2^ADDR_W
            end
        end
    end

    // Request, valid and error flags follow the state directly.
    assign bus.imem_req    = (state_q == WAIT);
    assign bus.imem_addr   = addr_q;
    assign bus.id_valid    = (state_q == OUT);
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign fetch_err       = (state_q == ERR);

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit: table of fetches plus hand-written
// sequences for back-pressure, flush, timeout and reset.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_addr = 32'h0;
    logic        pc_en;
    logic        flush = 1'b0;
    logic        fetch_err;
    logic        id_ready = 1'b0;

    // Memory model controls.
    int          mem_delay = 0;
    logic        no_ack = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        mem_ack = 1'b0;
    int          mem_cnt = 0;

    int errors = 0;
    int checks = 0;
    int pc_en_pulses = 0;
    logic dead_seen = 1'b0;

    if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    assign bus.imem_ack   = mem_ack;
    assign bus.imem_rdata = mem_data;
    assign bus.id_ready   = id_ready;

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_addr   (pc_addr),
        .pc_en     (pc_en),
        .flush     (flush),
        .fetch_err (fetch_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Memory: acks in the (mem_delay+1)-th cycle of an outstanding request.
    always @(negedge clk) begin
        if (bus.imem_req && !no_ack) begin
            if (mem_cnt >= mem_delay) begin
                mem_ack <= 1'b1;
                mem_cnt <= 0;
            end else begin
                mem_ack <= 1'b0;
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_ack <= 1'b0;
            mem_cnt <= 0;
        end
    end

    always @(posedge clk) begin
        if (pc_en === 1'b1) pc_en_pulses <= pc_en_pulses + 1;
    end

    always @(negedge clk) begin
        if (bus.id_valid && bus.id_instr == 32'hDEAD_BEEF) dead_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.id_valid) seen = 1'b1;
        end
        check({name, "_valid_seen"}, {31'b0, seen}, 32'd1);
    endtask

    task automatic wait_req(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.imem_req) seen = 1'b1;
        end
        check({name, "_req_seen"}, {31'b0, seen}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int base;
        int n;
        bit done;
        bit valid_seen;
        bit found;

        vecs[0] = '{32'h0000_0100, 32'h8C08_0004, 32'h8C08_0004, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0040_0FF8, 32'hAC09_0008, 32'hAC09_0008, 32'h0040_0FF8, 32'h0040_0FFC};
        vecs[2] = '{32'hFFFF_FFFC, 32'h1000_FFFF, 32'h1000_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h7FFF_FFFC, 32'h2409_FFFF, 32'h2409_FFFF, 32'h7FFF_FFFC, 32'h8000_0000};

        // Reset values.
        mem_data = 32'h2002_0005;
        #12;
        check("rst_pc_en",       pc_en,           32'h0);
        check("rst_imem_req",    bus.imem_req,    32'h0);
        check("rst_id_valid",    bus.id_valid,    32'h0);
        check("rst_fetch_err",   fetch_err,       32'h0);
        check("rst_imem_addr",   bus.imem_addr,   32'h0);
        check("rst_id_pc",       bus.id_pc,       32'h0);
        check("rst_id_pc_plus4", bus.id_pc_plus4, 32'h0);
        check("rst_id_instr",    bus.id_instr,    32'h0);

        // First fetch: cycles REQ, WAIT, OUT after release.
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        check("first_wait_valid", bus.id_valid,  32'h0);
        check("first_wait_req",   bus.imem_req,  32'h1);
        check("first_wait_addr",  bus.imem_addr, 32'h0);
        @(posedge clk) #1;
        check("first_valid",  bus.id_valid,    32'h1);
        check("first_instr",  bus.id_instr,    32'h2002_0005);
        check("first_pc",     bus.id_pc,       32'h0);
        check("first_pc4",    bus.id_pc_plus4, 32'h4);

        // Back-pressure for 5 cycles.
        base = pc_en_pulses;
        repeat (5) begin
            @(negedge clk);
            check("bp_pc_en", pc_en,        32'h0);
            check("bp_valid", bus.id_valid, 32'h1);
            check("bp_instr", bus.id_instr, 32'h2002_0005);
            check("bp_pc",    bus.id_pc,    32'h0);
        end
        id_ready = 1'b1;
        #1;
        check("hs_pc_en", pc_en, 32'h1);
        @(posedge clk) #1;
        check("hs_one_pulse", pc_en_pulses - base, 32'd1);
        check("hs_valid_drop", bus.id_valid, 32'h0);

        // Table of straight fetches, decode always ready.
        for (int i = 0; i < 4; i++) begin
            pc_addr  = vecs[i].pc;
            mem_data = vecs[i].rdata;
            wait_valid("tbl");
            check("tbl_instr", bus.id_instr,    vecs[i].exp_instr);
            check("tbl_pc",    bus.id_pc,       vecs[i].exp_pc);
            check("tbl_pc4",   bus.id_pc_plus4, vecs[i].exp_pc4);
            check("tbl_pc_en", pc_en,           32'h1);
            @(posedge clk) #1;
        end

        // Flush in the first WAIT cycle, ack 3 cycles late.
        pc_addr   = 32'h20;
        mem_data  = 32'hDEAD_BEEF;
        mem_delay = 3;
        base      = pc_en_pulses;
        @(posedge clk) #1;
        check("fw_req",  bus.imem_req,  32'h1);
        check("fw_addr", bus.imem_addr, 32'h20);
        flush   = 1'b1;
        pc_addr = 32'h40;
        @(posedge clk) #1;
        flush = 1'b0;
        check("fw_req_held", bus.imem_req, 32'h1);
        found = 1'b0;
        valid_seen = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.id_valid) valid_seen = 1'b1;
            if (bus.imem_req && bus.imem_addr == 32'h40) found = 1'b1;
        end
        check("fw_refetch_seen", {31'b0, found},      32'd1);
        check("fw_no_valid",     {31'b0, valid_seen}, 32'd0);
        mem_data = 32'h1111_2222;
        wait_valid("fw");
        check("fw_instr",     bus.id_instr,              32'h1111_2222);
        check("fw_pc",        bus.id_pc,                 32'h40);
        check("fw_no_dead",   {31'b0, dead_seen},        32'd0);
        check("fw_no_pc_en",  pc_en_pulses - base,       32'd0);
        @(posedge clk) #1;

        // Flush together with id_ready in OUT.
        mem_delay = 0;
        pc_addr   = 32'h80;
        mem_data  = 32'h3333_4444;
        wait_valid("fo");
        check("fo_instr", bus.id_instr, 32'h3333_4444);
        flush   = 1'b1;
        pc_addr = 32'hC0;
        base    = pc_en_pulses;
        #1;
        check("fo_pc_en", pc_en, 32'h0);
        @(posedge clk) #1;
        flush = 1'b0;
        check("fo_valid_drop", bus.id_valid,        32'h0);
        check("fo_no_pulse",   pc_en_pulses - base, 32'd0);
        wait_req("fo");
        check("fo_next_addr", bus.imem_addr, 32'hC0);
        wait_valid("fo2");
        check("fo_next_pc", bus.id_pc, 32'hC0);
        @(posedge clk) #1;

        // Timeout: no ack ever.
        no_ack  = 1'b1;
        pc_addr = 32'h200;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (fetch_err) done = 1'b1;
            else if (bus.imem_req) n++;
        end
        check("to_err_seen",    {31'b0, done}, 32'd1);
        check("to_wait_cycles", n,             32'd16);
        no_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flush = i[0];
            @(negedge clk);
            check("err_req",   bus.imem_req, 32'h0);
            check("err_valid", bus.id_valid, 32'h0);
            check("err_pc_en", pc_en,        32'h0);
            check("err_sticky", fetch_err,   32'h1);
        end
        flush = 1'b0;

        // Reset clears the error; fetching resumes.
        rst_n = 1'b0;
        #1;
        check("rr_fetch_err", fetch_err,    32'h0);
        check("rr_req",       bus.imem_req, 32'h0);
        check("rr_id_pc",     bus.id_pc,    32'h0);
        check("rr_id_instr",  bus.id_instr, 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        pc_addr  = 32'h300;
        mem_data = 32'h0800_00C0;
        wait_valid("rr");
        check("rr_pc",    bus.id_pc,    32'h300);
        check("rr_instr", bus.id_instr, 32'h0800_00C0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch consumer sitting between the Program_counter output and the IF/ID stage.
- Takes the current PC address and issues a req/ack read to instruction memory.
- Presents the returned instruction to decode with a valid/ready handshake.
- Pulses a PC-enable so the PC advances only when an instruction has been accepted.
- Handles branch flush and memory-timeout error.

Parameters:
- ADDR_W, 32, PC/instruction address width
- DATA_W, 32, instruction word width
- TIMEOUT, 16, max cycles in WAIT without imem_ack before error (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_addr  in  ADDR_W  current PC value (Program_counter output)
- pc_en  out  1  one-cycle pulse: PC may load its next value at the coming edge
- imem_req  out  1  read request, held high until ack
- imem_addr  out  ADDR_W  read address, stable while imem_req=1
- imem_ack  in  1  single-cycle response strobe, rdata valid same cycle
- imem_rdata  in  DATA_W  instruction word
- flush  in  1  branch/jump redirect; PC is reloaded externally at the same edge
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts instruction
- id_instr  out  DATA_W  fetched instruction
- id_pc  out  ADDR_W  address of id_instr
- id_pc_plus4  out  ADDR_W  id_pc + 4, modulo 2^ADDR_W
- fetch_err  out  1  sticky timeout error

Behaviour:
- Interface: one clock, clk; reset asynchronous, active-low, port rst_n.
- Reset values:
  - pc_en, imem_req, id_valid, fetch_err = 0
  - imem_addr, id_pc, id_pc_plus4 = 0
  - id_instr = NOP (32'h0000_0000)
  - state = REQ on the first edge after deassertion
- States:
  - REQ: addr_q <= pc_addr; timeout counter cleared; -> WAIT. imem_req=0 in this cycle.
  - WAIT: imem_req=1, imem_addr=addr_q.
    - On imem_ack with drop=0: id_instr <= imem_rdata, id_pc <= addr_q, id_pc_plus4 <= addr_q+4, id_valid <= 1; -> OUT.
    - On imem_ack with drop=1: discard data, clear drop; -> REQ.
    - If the counter reaches TIMEOUT-1 without ack: fetch_err <= 1; -> ERR.
  - OUT: id_valid=1, outputs held stable until id_valid&id_ready.
    - Handshake cycle: pc_en=1 (combinational); next edge id_valid <= 0; -> REQ.
  - ERR: terminal until reset. All request/valid/enable outputs 0; fetch_err=1.
- Latency: ack cycle t -> id_valid at t+1. Zero-wait memory gives one instruction per 3 cycles (REQ, WAIT, OUT).
- pc_en is asserted only in an OUT handshake cycle without flush. It is never asserted in REQ, WAIT or ERR.
- flush in REQ: -> REQ again; re-sample pc_addr next cycle, which then holds the redirected PC.
- flush in WAIT: set drop; imem_req stays high until the outstanding ack is consumed (no abandoned transaction), then REQ.
- flush in WAIT together with imem_ack: data discarded, -> REQ.
- flush in OUT: id_valid <= 0; -> REQ; pc_en=0 even if id_ready=1 (flush wins).
- Reset mid-transaction: everything returns to reset values immediately. The memory side must tolerate a dropped request.
- imem_ack outside WAIT is ignored.

Decomposition:
- Shared package mips_pkg:
  - MIPS_NOP constant (32'h0)
  - fetch-state enum {REQ, WAIT, OUT, ERR}
  - PC_INCR = 4
- One natural sub-module: fetch_timeout_ctr, a clear/enable saturating counter with a terminal-count flag, parameterised by TIMEOUT.
- The FSM and output registers stay in the top module.

Test Plan:
- Reset, PC=0, zero-wait memory returning 0x2002_0005:
  - id_valid rises 3 cycles after reset release, id_pc=0, id_pc_plus4=4.
  - With id_ready=1, pc_en pulses once.
- Back-pressure: hold id_ready=0 for 5 cycles.
  - id_instr/id_pc stable, pc_en=0 throughout.
  - Raising id_ready gives exactly one pc_en pulse.
- Flush in WAIT:
  - ack delayed 3 cycles with rdata=0xDEAD_BEEF, flush asserted in first WAIT cycle, pc_addr becomes 0x40.
  - 0xDEAD_BEEF is never presented; next imem_addr=0x40.
- Flush and id_ready together in OUT:
  - id_valid drops next cycle, pc_en stays 0, next fetch address = new pc_addr.
- Timeout, TIMEOUT=16, no ack:
  - fetch_err=1 after 16 WAIT cycles; imem_req=0, id_valid=0 thereafter.
  - Clears only on rst_n low.
- PC wrap: pc_addr=0xFFFF_FFFC -> id_pc_plus4=0x0000_0000.
